// File: rtl/output_rd_ctrl_if.sv
// Handshake bundle between the per-port read controller and its neighbours
// (arbiter grant, queue manager, read engine, length parser, block free list).
interface output_rd_ctrl_if #(
  parameter int PORTNUM        = 16,
  parameter int BLK_ADDR_WIDTH = 10,
  parameter int LEN_WIDTH      = 10,
  parameter int BLK_BYTES      = 64,
  parameter int BUS_BYTES      = 4
);
  localparam int PORT_W = (PORTNUM > 1) ? $clog2(PORTNUM) : 1;
  localparam int BEATS  = BLK_BYTES / BUS_BYTES;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  logic [PORT_W-1:0]         i_port;
  logic                      i_port_vld;
  logic                      o_port_rdy;
  logic                      o_addr_req;
  logic [PORT_W-1:0]         o_addr_port;
  logic [BLK_ADDR_WIDTH-1:0] i_addr;
  logic                      i_addr_vld;
  logic                      o_rd_vld;
  logic                      i_rd_rdy;
  logic [BLK_ADDR_WIDTH-1:0] o_rd_addr;
  logic [BEAT_W-1:0]         o_rd_beats;
  logic                      o_rd_last;
  logic                      i_rd_done;
  logic [LEN_WIDTH-1:0]      i_len;
  logic                      i_len_vld;
  logic [BLK_ADDR_WIDTH-1:0] o_rls_addr;
  logic                      o_rls_vld;
  logic                      o_pkt_done;
  logic [PORT_W-1:0]         o_pkt_port;

  // Controller side.
  modport master (
    input  i_port, i_port_vld, i_addr, i_addr_vld, i_rd_rdy, i_rd_done, i_len, i_len_vld,
    output o_port_rdy, o_addr_req, o_addr_port, o_rd_vld, o_rd_addr, o_rd_beats, o_rd_last,
           o_rls_addr, o_rls_vld, o_pkt_done, o_pkt_port
  );

  // Environment side.
  modport slave (
    output i_port, i_port_vld, i_addr, i_addr_vld, i_rd_rdy, i_rd_done, i_len, i_len_vld,
    input  o_port_rdy, o_addr_req, o_addr_port, o_rd_vld, o_rd_addr, o_rd_beats, o_rd_last,
           o_rls_addr, o_rls_vld, o_pkt_done, o_pkt_port
  );
endinterface

// File: rtl/output_rd_ctrl.sv
// Per-output-port packet read controller: fetches block addresses, issues exact-length reads, frees blocks.
// Release follows read completion by 1 cycle; every request/command holds until its handshake completes.
module output_rd_ctrl #(
  parameter int PORTNUM        = 16,
  parameter int BLK_ADDR_WIDTH = 10,
  parameter int LEN_WIDTH      = 10,
  parameter int BLK_BYTES      = 64,
  parameter int BUS_BYTES      = 4,
  parameter int HDR_BYTES      = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  output_rd_ctrl_if.master bus
);
  localparam int PORT_W = (PORTNUM > 1) ? $clog2(PORTNUM) : 1;
  localparam int BEATS  = BLK_BYTES / BUS_BYTES;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int BLK_SH = $clog2(BLK_BYTES);
  localparam int BUS_SH = $clog2(BUS_BYTES);
  localparam int TOT_W  = LEN_WIDTH + 2;

  typedef enum logic [2:0] {IDLE, REQ, ISSUE, WAIT_DONE, WAIT_LEN, DONE} state_t;

  state_t                    state;
  logic [PORT_W-1:0]         port_q;
  logic [BLK_ADDR_WIDTH-1:0] addr_q;
  logic                      first;
  logic                      len_known;
  logic [TOT_W-1:0]          blk_left;
  logic [BEAT_W-1:0]         last_m1;

  logic                      port_rdy;
  logic                      addr_req;
  logic                      rd_vld;
  logic [BLK_ADDR_WIDTH-1:0] rd_addr;
  logic [BEAT_W-1:0]         rd_beats;
  logic                      rd_last;
  logic                      rls_vld;
  logic [BLK_ADDR_WIDTH-1:0] rls_addr;
  logic                      pkt_done;
  logic [PORT_W-1:0]         pkt_port;

  logic [TOT_W-1:0]  tot;
  logic [TOT_W-1:0]  tot_rem;
  logic [TOT_W-1:0]  lb_bytes;
  logic [TOT_W-1:0]  lb_beats;
  logic [TOT_W-1:0]  len_left;
  logic [BEAT_W-1:0] len_last_m1;
  logic              len_take;
  logic              eff_known;
  logic [TOT_W-1:0]  eff_left;
  logic [TOT_W-1:0]  nxt_left;
  logic              adv;

  // Length decode: header rides in front of the payload, so the byte count spans tot bytes.
  always_comb begin
    tot         = TOT_W'(bus.i_len) + TOT_W'(HDR_BYTES);
    tot_rem     = tot & TOT_W'(BLK_BYTES - 1);
    lb_bytes    = (tot_rem == '0) ? TOT_W'(BLK_BYTES) : tot_rem;
    lb_beats    = (lb_bytes + TOT_W'(BUS_BYTES - 1)) >> BUS_SH;
    len_left    = ((tot + TOT_W'(BLK_BYTES - 1)) >> BLK_SH) - TOT_W'(1);
    len_last_m1 = BEAT_W'(lb_beats - TOT_W'(1));
    len_take    = bus.i_len_vld && !len_known &&
                  (state == ISSUE || state == WAIT_DONE || state == WAIT_LEN);
    eff_known   = len_known || len_take;
    eff_left    = len_take ? len_left : blk_left;
    // After the first block blk_left counts remaining blocks; later it includes the block just read.
    nxt_left    = first ? eff_left : (eff_left - TOT_W'(1));
    adv         = (state == WAIT_DONE && bus.i_rd_done && !(first && !eff_known)) ||
                  (state == WAIT_LEN && len_take);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= IDLE;
      port_q    <= '0;
      addr_q    <= '0;
      first     <= 1'b0;
      len_known <= 1'b0;
      blk_left  <= '0;
      last_m1   <= '0;
      port_rdy  <= 1'b0;
      addr_req  <= 1'b0;
      rd_vld    <= 1'b0;
      rd_addr   <= '0;
      rd_beats  <= '0;
      rd_last   <= 1'b0;
      rls_vld   <= 1'b0;
      rls_addr  <= '0;
      pkt_done  <= 1'b0;
      pkt_port  <= '0;
    end else begin
      rls_vld  <= 1'b0;
      rls_addr <= '0;
      pkt_done <= 1'b0;
      pkt_port <= '0;

      if (len_take) begin
        len_known <= 1'b1;
        blk_left  <= len_left;
        last_m1   <= len_last_m1;
      end

      case (state)
        IDLE: begin
          port_rdy <= 1'b1;
          if (port_rdy && bus.i_port_vld) begin
            port_q    <= bus.i_port;
            first     <= 1'b1;
            len_known <= 1'b0;
            blk_left  <= '0;
            port_rdy  <= 1'b0;
            addr_req  <= 1'b1;
            state     <= REQ;
          end
        end
        REQ: begin
          if (bus.i_addr_vld) begin
            addr_req <= 1'b0;
            addr_q   <= bus.i_addr;
            rd_vld   <= 1'b1;
            rd_addr  <= bus.i_addr;
            // The first block is always read whole; the engine trims beyond the length.
            if (!first && blk_left == TOT_W'(1)) begin
              rd_beats <= last_m1;
              rd_last  <= 1'b1;
            end else begin
              rd_beats <= BEAT_W'(BEATS - 1);
              rd_last  <= 1'b0;
            end
            state <= ISSUE;
          end
        end
        ISSUE: begin
          if (bus.i_rd_rdy) begin
            rd_vld <= 1'b0;
            state  <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          if (bus.i_rd_done) begin
            rls_vld  <= 1'b1;
            rls_addr <= addr_q;
            if (!adv) state <= WAIT_LEN;
          end
        end
        WAIT_LEN: begin
        end
        DONE: begin
          port_rdy <= 1'b1;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase

      if (adv) begin
        first <= 1'b0;
        if (nxt_left == '0) begin
          pkt_done <= 1'b1;
          pkt_port <= port_q;
          state    <= DONE;
        end else begin
          blk_left <= nxt_left;
          addr_req <= 1'b1;
          state    <= REQ;
        end
      end
    end
  end

  assign bus.o_port_rdy  = port_rdy;
  assign bus.o_addr_req  = addr_req;
  assign bus.o_addr_port = addr_req ? port_q : '0;
  assign bus.o_rd_vld    = rd_vld;
  assign bus.o_rd_addr   = rd_addr;
  assign bus.o_rd_beats  = rd_beats;
  assign bus.o_rd_last   = rd_last;
  assign bus.o_rls_vld   = rls_vld;
  assign bus.o_rls_addr  = rls_addr;
  assign bus.o_pkt_done  = pkt_done;
  assign bus.o_pkt_port  = pkt_port;
endmodule

// File: doc/output_rd_ctrl.md
Name: output_rd_ctrl

Overview:
Per-output-port packet read controller and parametrised successor of the single-mode output controller. It accepts a granted source port and fetches that port's block addresses from the queue manager one at a time. For each block it issues a read command with an exact beat count to the memory read engine and releases each block address once its read completes. Block size, bus width and header size are generic parameters, and every interface carries a handshake or an explicit per-block release.

Parameters:
PORTNUM, 16, number of source ports; PORT_W = $clog2(PORTNUM)
BLK_ADDR_WIDTH, 10, block address width
LEN_WIDTH, 10, packet payload length width in bytes
BLK_BYTES, 64, bytes per memory block (power of two)
BUS_BYTES, 4, bytes per read beat (power of two, <= BLK_BYTES); BEATS = BLK_BYTES/BUS_BYTES, BEAT_W = $clog2(BEATS) (min 1)
HDR_BYTES, 4, header bytes stored ahead of the payload in the first block (< BLK_BYTES)

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous active-high reset
i_port  in  PORT_W  granted source port
i_port_vld  in  1  grant strobe; accepted only while o_port_rdy=1
o_port_rdy  out  1  high in IDLE
o_addr_req  out  1  request for the next block address of o_addr_port
o_addr_port  out  PORT_W  port being served
i_addr  in  BLK_ADDR_WIDTH  returned block address
i_addr_vld  in  1  address valid; completes the request
o_rd_vld  out  1  read command valid
i_rd_rdy  in  1  read engine accepts the command
o_rd_addr  out  BLK_ADDR_WIDTH  block to read
o_rd_beats  out  BEAT_W  beats-1 for this block
o_rd_last  out  1  block is the last of the packet
i_rd_done  in  1  current block read complete (1-cycle pulse)
i_len  in  LEN_WIDTH  payload length parsed from the header
i_len_vld  in  1  length strobe, raised during or after the first block read
o_rls_addr  out  BLK_ADDR_WIDTH  block address to free
o_rls_vld  out  1  release pulse
o_pkt_done  out  1  packet-complete pulse
o_pkt_port  out  PORT_W  port of the completed packet

Behaviour:
- Reset: all outputs 0 except o_port_rdy=0 during reset and 1 on the first cycle after; all counters and flags are cleared. A reset mid-packet abandons the packet: no release and no done pulse.
- States: IDLE, REQ, ISSUE, WAIT_DONE, WAIT_LEN, DONE.
- IDLE: o_port_rdy=1. When i_port_vld=1, latch i_port, set first=1, len_known=0, then go to REQ.
- REQ: o_addr_req=1 and o_addr_port=latched port, held until i_addr_vld. i_addr_vld may arrive in the same cycle the request is raised. On i_addr_vld, capture i_addr and go to ISSUE. i_addr_vld is ignored in all other states.
- ISSUE: o_rd_vld=1 and the command fields are held stable until i_rd_rdy=1; then go to WAIT_DONE.
  - First block: o_rd_beats=BEATS-1, o_rd_last=0.
  - Later blocks: o_rd_beats=BEATS-1, or last_beats-1 when blk_left==1; o_rd_last=(blk_left==1).
- Length capture: i_len_vld is sampled in ISSUE, WAIT_DONE and WAIT_LEN; the first strobe per packet wins. It computes:
  - tot = i_len + HDR_BYTES, width LEN_WIDTH+1
  - blk_total = ceil(tot/BLK_BYTES)
  - last_bytes = tot mod BLK_BYTES, or BLK_BYTES if that is 0
  - last_beats = ceil(last_bytes/BUS_BYTES)
  - blk_left = blk_total-1 (accounts for the first block)
  - len_known=1
- i_len=0 is legal and gives 1 block.
- WAIT_DONE, on i_rd_done:
  - The next cycle pulses o_rls_vld with o_rls_addr = the current address (one release per block, latency 1).
  - If first and len_known=0, go to WAIT_LEN.
  - Otherwise clear first; if blk_left==0 go to DONE, else decrement blk_left (when it was not the first block) and go to REQ.
- i_len_vld and i_rd_done in the same cycle: the length is used for that decision.
- WAIT_LEN: on i_len_vld, capture the length and apply the same decision.
- DONE: o_pkt_done=1 and o_pkt_port=port for one cycle, then IDLE. i_port_vld is ignored outside IDLE.
- The first block is always read in full (BEATS); the read engine discards beats past the length.

Test Plan:
- BLK 64/BUS 4/HDR 4; port 3, len=60 arriving during block 0 -> one read (beats=15, last=0), one release, o_pkt_done with port 3; no second o_addr_req.
- len=61 -> 2 reads; second read has beats=0, last=1; 2 releases of the two returned addresses in order; done.
- len=200 (tot 204) -> 4 reads with beats 15,15,15,2; o_rd_last only on the 4th.
- len=0, with i_len_vld arriving 10 cycles after i_rd_done -> FSM sits in WAIT_LEN, then 1 block, done.
- i_rd_rdy held low 5 cycles in ISSUE -> o_rd_vld/addr/beats stable throughout; i_port_vld pulses mid-packet are ignored.
- i_rst asserted in WAIT_DONE of block 2 -> all outputs 0 next cycle, no o_rls_vld/o_pkt_done; a new packet afterwards runs correctly.
